// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   alu_mode_e  : operation select encoding (mode input values 0x0..0xD;
//                 0xE/0xF are unnamed and produce c=0)
//   alu_state_e : control FSM states, also exported on the debug port
//   FLG_*       : bit positions inside the 4-bit flags vector
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_ADC  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_SBB  = 4'h3,
        ALU_SHL  = 4'h4,
        ALU_SHR  = 4'h5,
        ALU_AND  = 4'h6,
        ALU_OR   = 4'h7,
        ALU_NOT  = 4'h8,
        ALU_XOR  = 4'h9,
        ALU_NAND = 4'hA,
        ALU_NOR  = 4'hB,
        ALU_MUL  = 4'hC,
        ALU_CMP  = 4'hD
    } alu_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int FLG_C  = 0;
    localparam int FLG_B  = 1;
    localparam int FLG_Z  = 2;
    localparam int FLG_LT = 3;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath of the sequential ALU.
// Ports:
//   a, b        : operands
//   mode        : operation select (alu_mode_e encoding)
//   carry_in    : carry consumed by ADC
//   borrow_in   : borrow consumed by SBB
//   result      : WIDTH-bit result; SHL/SHR/CMP pass a through (zero-length
//                 shift case), MUL and 0xE/0xF return 0 (MUL is iterated
//                 by the top level)
//   carry_out   : carry out of the WIDTH-bit add
//   borrow_out  : borrow out of the WIDTH-bit subtract
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode,
    input  logic             carry_in,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow_out
);

    logic           add_cin;
    logic           sub_bin;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Plain ADD/SUB ignore the stored carry/borrow.
    assign add_cin = (mode == ALU_ADC) & carry_in;
    assign sub_bin = (mode == ALU_SBB) & borrow_in;

    // One extra bit captures carry out; for the subtract the extra bit is
    // set exactly when the true difference went negative (borrow).
    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};

    assign carry_out  = sum[WIDTH];
    assign borrow_out = diff[WIDTH];

    always_comb begin
        result = '0;
        case (mode)
            ALU_ADD, ALU_ADC:          result = sum[WIDTH-1:0];
            ALU_SUB, ALU_SBB:          result = diff[WIDTH-1:0];
            ALU_SHL, ALU_SHR, ALU_CMP: result = a;
            ALU_AND:                   result = a & b;
            ALU_OR:                    result = a | b;
            ALU_NOT:                   result = ~a;
            ALU_XOR:                   result = a ^ b;
            ALU_NAND:                  result = ~(a & b);
            ALU_NOR:                   result = ~(a | b);
            default:                   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshaked operands in, handshaked result out, with a
// persistent flags register feeding ADC/SBB, bit-serial variable shifts and
// a WIDTH-cycle shift-add multiply.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : operands/mode presented      in_ready : idle, can accept
//   a, b, mode  : operands and operation; b[SHW-1:0] is the shift amount
//   flags_clr   : clear flags register (honoured in IDLE only)
//   out_valid   : result held               out_ready : consumer takes it
//   c           : registered result
//   flags       : {lt, zero, borrow, carry}
//   dbg_state   : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and stays high, with c/flags stable, until out_ready is seen.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode,
    input  logic             flags_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags,
    output alu_state_e       dbg_state
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;     // counter must reach WIDTH for MUL

    alu_state_e       state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b, work;
    logic [3:0]       op_mode, flag_q;
    logic [2*WIDTH-1:0] prod;

    logic             accept, exec_last, is_shift;
    logic [SHW-1:0]   shamt;
    logic [3:0]       base_flags, single_flags, exec_flags;
    logic [WIDTH-1:0] comb_result, exec_result, work_shl, work_shr;
    logic             comb_carry, comb_borrow;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod_nx;

    assign shamt    = b[SHW-1:0];
    assign is_shift = (mode == ALU_SHL) || (mode == ALU_SHR);

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign flags     = flag_q;
    assign dbg_state = state;

    // A clear arriving with an operation takes effect before the operation.
    assign base_flags = flags_clr ? 4'h0 : flag_q;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a          (a),
        .b          (b),
        .mode       (mode),
        .carry_in   (base_flags[FLG_C]),
        .borrow_in  (base_flags[FLG_B]),
        .result     (comb_result),
        .carry_out  (comb_carry),
        .borrow_out (comb_borrow)
    );

    always_comb begin
        single_flags         = base_flags;
        single_flags[FLG_Z]  = (comb_result == '0);
        single_flags[FLG_LT] = (a < b);
        if (mode == ALU_ADD || mode == ALU_ADC) single_flags[FLG_C] = comb_carry;
        if (mode == ALU_SUB || mode == ALU_SBB) single_flags[FLG_B] = comb_borrow;
    end

    // One iteration step. Multiplier sits in prod's low half and is consumed
    // LSB first while partial sums accumulate in the upper half.
    assign work_shl = {work[WIDTH-2:0], 1'b0};
    assign work_shr = {1'b0, work[WIDTH-1:1]};
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, op_a} : '0);
    assign prod_nx  = {mul_sum, prod[WIDTH-1:1]};

    always_comb begin
        exec_result = work_shr;
        if (op_mode == ALU_MUL)      exec_result = prod_nx[WIDTH-1:0];
        else if (op_mode == ALU_SHL) exec_result = work_shl;

        exec_flags         = flag_q;
        exec_flags[FLG_Z]  = (exec_result == '0);
        exec_flags[FLG_LT] = (op_a < op_b);
        if (op_mode == ALU_MUL)      exec_flags[FLG_C] = |prod_nx[2*WIDTH-1:WIDTH];
        else if (op_mode == ALU_SHL) exec_flags[FLG_C] = work[WIDTH-1];
        else                         exec_flags[FLG_B] = work[0];
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        exec_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if ((mode == ALU_MUL) || (is_shift && shamt != '0))
                        state_nx = ST_EXEC;
                    else
                        state_nx = ST_DONE;
                end
            end
            ST_EXEC: begin
                if (cnt == CW'(1)) begin
                    exec_last = 1'b1;
                    state_nx  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            c       <= '0;
            flag_q  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_mode <= '0;
            work    <= '0;
            prod    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (flags_clr) flag_q <= 4'h0;
                    if (accept) begin
                        op_a    <= a;
                        op_b    <= b;
                        op_mode <= mode;
                        if (mode == ALU_MUL) begin
                            prod <= {{WIDTH{1'b0}}, b};
                            cnt  <= CW'(WIDTH);
                        end else if (is_shift && shamt != '0) begin
                            work <= a;
                            cnt  <= {1'b0, shamt};
                        end else begin
                            c      <= comb_result;
                            flag_q <= single_flags;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt - CW'(1);
                    if (op_mode == ALU_MUL)      prod <= prod_nx;
                    else if (op_mode == ALU_SHL) work <= work_shl;
                    else                         work <= work_shr;
                    if (exec_last) begin
                        c      <= exec_result;
                        flag_q <= exec_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, flags_clr, out_valid, out_ready;
    logic [W-1:0] a, b, c;
    logic [3:0]   mode, flags;
    alu_state_e   dbg_state;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [3:0]   mflags;            // model flags {lt, zero, borrow, carry}
    logic [11:0]  exp_q[$];          // {flags, c} expected per accepted op

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .flags_clr (flags_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Integer arithmetic straight from the operation definitions.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] mm,
                         output logic [7:0] rc, output int lat);
        int ia, ib, r, n;
        logic cy, bw;
        ia  = ma;
        ib  = mb;
        n   = ib % 8;
        cy  = mflags[0];
        bw  = mflags[1];
        lat = 1;
        case (mm)
            4'h0: begin r = ia + ib;               cy = (r > 255); end
            4'h1: begin r = ia + ib + int'(cy);    cy = (r > 255); end
            4'h2: begin r = ia - ib;               bw = (r < 0);   end
            4'h3: begin r = ia - ib - int'(bw);    bw = (r < 0);   end
            4'h4: begin
                r = ia << n;
                if (n > 0) begin cy = ((ia >> (8 - n)) & 1) != 0; lat = n + 1; end
            end
            4'h5: begin
                r = ia >> n;
                if (n > 0) begin bw = ((ia >> (n - 1)) & 1) != 0; lat = n + 1; end
            end
            4'h6: r = ia & ib;
            4'h7: r = ia | ib;
            4'h8: r = ~ia;
            4'h9: r = ia ^ ib;
            4'hA: r = ~(ia & ib);
            4'hB: r = ~(ia | ib);
            4'hC: begin r = ia * ib; cy = (r > 255); lat = 9; end
            4'hD: r = ia;
            default: r = 0;
        endcase
        rc     = 8'(r & 255);
        mflags = {(ia < ib), (rc == 8'h00), bw, cy};
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [3:0] tm,
                          input bit clr, input int hold);
        logic [7:0]  rc;
        logic [11:0] e;
        int          lat_exp, lat;
        if (clr) mflags = 4'h0;
        model(ta, tbv, tm, rc, lat_exp);
        exp_q.push_back({mflags, rc});
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        check("out_valid_idle", out_valid, 0);
        a = ta; b = tbv; mode = tm; flags_clr = clr; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flags_clr = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check("latency", lat, lat_exp);
        e = exp_q.pop_front();
        check("c", c, e[7:0]);
        check("flags", flags, e[11:8]);
        // Backpressure: inputs must be ignored while the result is held.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; flags_clr = 1'b1;
            a = W'($urandom); b = W'($urandom); mode = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_c", c, e[7:0]);
            check("hold_flags", flags, e[11:8]);
        end
        in_valid = 1'b0; flags_clr = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; flags_clr = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = '0;
        mflags = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_flags", flags, 0);

        // Directed sequence
        run_op(8'h0F, 8'h01, 4'h0, 1'b0, 0);   // ADD -> 0x10
        check("add_c_const", c, 8'h10);
        run_op(8'hFF, 8'h01, 4'h1, 1'b0, 0);   // ADC -> 0x00, C=1 Z=1
        run_op(8'h00, 8'h00, 4'h1, 1'b0, 0);   // ADC uses carry -> 0x01
        check("adc_chain_const", c, 8'h01);
        run_op(8'h31, 8'h03, 4'h4, 1'b0, 0);   // SHL 3 -> 0x88, C=1
        run_op(8'h31, 8'h00, 4'h5, 1'b0, 0);   // SHR 0 -> 0x31, borrow held
        run_op(8'h10, 8'h10, 4'hC, 1'b0, 0);   // MUL -> 0x00, C=1 Z=1
        run_op(8'h0F, 8'h03, 4'hC, 1'b0, 5);   // MUL -> 0x2D with backpressure
        run_op(8'hFF, 8'h01, 4'h0, 1'b0, 0);   // set carry
        run_op(8'h00, 8'h00, 4'h1, 1'b1, 0);   // clear with op: ADC sees carry=0

        // Reset during the 4th EXEC cycle of a multiply
        @(negedge clk);
        a = 8'h37; b = 8'h5B; mode = 4'hC; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mflags = 4'h0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_c", c, 0);
        check("abort_flags", flags, 0);
        run_op(8'h03, 8'h05, 4'h2, 1'b0, 0);   // SUB -> 0xFE, B=1 LT=1
        check("sub_flags_const", flags, 4'b1010);

        // Randomized sequence
        for (int k = 0; k < 80; k++) begin
            run_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout global guard reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised sequential ALU, the successor to the 4-bit combinational ALU. It adds WIDTH generalisation, an internal persistent flags register that feeds ADC/SBB, multi-cycle variable shifts and a shift-add multiply. Operands and results pass through a valid/ready handshake, so the block sits between the register-file read stage and writeback in the core datapath.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand/mode presented
in_ready  out  1  block idle and able to accept
a  in  WIDTH  operand A
b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for SHL/SHR
mode  in  4  operation select
flags_clr  in  1  clear flags register (IDLE only)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
c  out  WIDTH  result
flags  out  4  {lt, zero, borrow, carry} = flags[3:0]

Behaviour:
- Reset: state=IDLE; in_ready=1 (combinational from state); out_valid=0; c=0; flags=0; multiply and shift counters=0. Reset mid-operation aborts the operation; no flag update.
- Mode map: 0 ADD, 1 ADC (a+b+carry), 2 SUB, 3 SBB (a-b-borrow), 4 SHL, 5 SHR (logical), 6 AND, 7 OR, 8 NOT a, 9 XOR, A NAND, B NOR, C MUL (low WIDTH bits), D CMP (c=a, flags only), E/F c=0.
- FSM IDLE -> EXEC -> DONE -> IDLE:
  - IDLE: in_ready=1. On in_valid, latch a, b and mode.
  - Single-cycle modes: go straight to DONE. c is registered at the accept edge, so out_valid=1 the next cycle (latency 1).
  - SHL/SHR with n=b[SHW-1:0]: n=0 goes to DONE with c=a and no carry/borrow change. Otherwise EXEC shifts one bit per cycle for n cycles, and out_valid rises the cycle after the nth shift.
  - MUL: shift-add in EXEC for exactly WIDTH cycles, then DONE. The product is held internally as 2*WIDTH bits.
  - DONE: out_valid=1; c and flags are stable. On out_ready, go to IDLE. in_ready asserts the following cycle, so peak throughput is one op per 2 cycles.
  - in_valid is ignored outside IDLE. out_valid never drops without out_ready.
- Flags register: written only on the transition into DONE. Fields not listed below hold their value.
  - carry: set by ADD/ADC (carry out of WIDTH); by SHL (last bit shifted out); by MUL (1 if upper WIDTH product bits != 0).
  - borrow: set by SUB/SBB (borrow out); by SHR (last bit shifted out).
  - zero = (c==0) for every mode.
  - lt = (a<b), unsigned, for every mode.
- ADC/SBB read the carry/borrow values held in the flags register at accept time.
- flags_clr in IDLE zeroes flags. If flags_clr and in_valid occur together, the clear happens first and the op sees carry=borrow=0. flags_clr is ignored in EXEC/DONE.
- All arithmetic is modulo 2^WIDTH. No X outputs for any mode.

Decomposition:
- Package alu_pkg: mode enum (ALU_ADD..ALU_CMP), FSM state enum, flag bit index constants (FLG_C=0, FLG_B=1, FLG_Z=2, FLG_LT=3).
- One sub-module, alu_comb: parametrised combinational single-cycle datapath. Inputs a, b, mode, carry_in, borrow_in; outputs result, carry_out, borrow_out.
- The top level owns the FSM, shift/multiply iteration and the flags register.

Test Plan:
- Reset then ADD, WIDTH=8, a=0x0F b=0x01 -> out_valid 1 cycle after accept, c=0x10, flags=0000.
- ADC a=0xFF b=0x01 -> c=0x00, carry=1, zero=1. Then ADC a=0x00 b=0x00 -> c=0x01, carry=0.
- SHL a=0x31 b=3 -> 3 EXEC cycles, c=0x88, carry=1. Then SHR a=0x31 b=0 -> c=0x31 after 1 cycle, borrow unchanged.
- MUL a=0x10 b=0x10 -> out_valid 9 cycles after accept, c=0x00, carry=1, zero=1. MUL a=0x0F b=0x03 -> c=0x2D, carry=0, lt=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> c, flags and out_valid stable; in_ready=0; in_valid pulses ignored.
- rst asserted at EXEC cycle 4 of a MUL -> next cycle in IDLE, out_valid=0, c=0, flags=0. Then a SUB a=0x03 b=0x05 -> c=0xFE, borrow=1, lt=1.
